// File: rtl/booth_div.sv
// Signed 32/16 restoring divider: one shift-subtract step per cycle on operand
// magnitudes, followed by a single sign-fix cycle and a one-cycle done pulse.
module booth_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] prem_q, prem_d;    // partial remainder
    logic [31:0] qmag_q, qmag_d;    // dividend magnitude shifting into quotient magnitude
    logic [15:0] dvs_q, dvs_d;      // divisor magnitude
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dzp_q, dzp_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dz_q, dz_d;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        q_over;
    logic [31:0] dvd_abs;
    logic [15:0] dvs_abs;

    // Datapath helpers: operand magnitudes, one restoring step and overflow test
    always_comb begin
        dvd_abs = dividend[31] ? (32'd0 - dividend) : dividend;
        dvs_abs = divisor[15] ? (16'd0 - divisor) : divisor;
        shifted = {prem_q[31:0], qmag_q[31]};
        diff    = shifted - {17'd0, dvs_q};
        // A negative quotient may reach -32768, a non-negative one only +32767
        q_over  = qneg_q ? (qmag_q > 32'd32768) : (qmag_q > 32'd32767);
    end

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        qmag_d  = qmag_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzp_d   = dzp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    qmag_d = dvd_abs;
                    dvs_d  = dvs_abs;
                    prem_d = 33'd0;
                    cnt_d  = 5'd0;
                    rneg_d = dividend[31];
                    qneg_d = dividend[31] ^ divisor[15];
                    dzp_d  = (divisor == 16'd0);
                    state_d = (divisor == 16'd0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (!diff[32]) begin
                    prem_d = diff;
                    qmag_d = {qmag_q[30:0], 1'b1};
                end else begin
                    prem_d = shifted;
                    qmag_d = {qmag_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dzp_q) begin
                    quo_d = 16'd0;
                    rem_d = 16'd0;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else if (q_over) begin
                    quo_d = 16'd0;
                    rem_d = 16'd0;
                    ovf_d = 1'b1;
                    dz_d  = 1'b0;
                end else begin
                    quo_d = qneg_q ? (16'd0 - qmag_q[15:0]) : qmag_q[15:0];
                    // Remainder is below the divisor magnitude, so 16 bits always hold it
                    rem_d = rneg_q ? (16'd0 - prem_q[15:0]) : prem_q[15:0];
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                end
                cnt_d   = 5'd0;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            prem_q  <= 33'd0;
            qmag_q  <= 32'd0;
            dvs_q   <= 16'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            quo_q   <= 16'd0;
            rem_q   <= 16'd0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            qmag_q  <= qmag_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzp_q   <= dzp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Status and result outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        q    = quo_q;
        r    = rem_q;
        ovf  = ovf_q;
        dz   = dz_q;
    end

endmodule

// File: tb/tb_booth_div.sv
module tb_booth_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dz;

    int checks;
    int failures;

    booth_div dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .ovf      (ovf),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division from a negedge; report results at the done cycle.
    // lat counts negedges after the start edge; 0 means done never came.
    task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] oq, output logic [15:0] orr,
                         output logic oovf, output logic odz,
                         output int lat, output logic busy_ok);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        oq = 16'hxxxx; orr = 16'hxxxx; oovf = 1'bx; odz = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                oq = q; orr = r; oovf = ovf; odz = dz;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 16'd3;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, q, r, ovf, dz} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
                     busy, done, q, r, ovf, dz);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
        do_op(32'hFFFFFFCE, 16'hFFFE, oq, orr, oovf, odz, lat, bok);
        checks++;
        if ({oq, orr, oovf, odz} !== {16'h0019, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL neg50_div_neg2: got q=%h r=%h ovf=%b dz=%b, want 0019 0000 0 0",
                     oq, orr, oovf, odz);
        end
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL latency_34: got %0d, want 34", lat);
        end
        checks++;
        if (bok !== 1'b1) begin
            failures++;
            $display("FAIL busy_throughout: got %b, want 1", bok);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_values;
        logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
        logic [31:0] va [7];
        logic [15:0] vb [7];
        logic [33:0] ve [7];    // {q, r, ovf, dz}
        string       vn [7];
        va[0] = 32'h3FFF0001; vb[0] = 16'h7FFF; ve[0] = {16'h7FFF, 16'h0000, 2'b00}; vn[0] = "max_pos";
        va[1] = 32'hC0008000; vb[1] = 16'h7FFF; ve[1] = {16'h8000, 16'h0000, 2'b00}; vn[1] = "min_neg";
        va[2] = 32'hFFFFE9CB; vb[2] = 16'd58;   ve[2] = {16'hFF9E, 16'hFFFF, 2'b00}; vn[2] = "neg5685_58";
        va[3] = 32'h40000000; vb[3] = 16'h7FFF; ve[3] = {16'h0000, 16'h0000, 2'b10}; vn[3] = "ovf_pos";
        va[4] = 32'h80000000; vb[4] = 16'hFFFF; ve[4] = {16'h0000, 16'h0000, 2'b10}; vn[4] = "ovf_min_m1";
        va[5] = 32'h40000000; vb[5] = 16'h8000; ve[5] = {16'h8000, 16'h0000, 2'b00}; vn[5] = "neg_edge";
        va[6] = 32'd1000;     vb[6] = 16'd7;    ve[6] = {16'd142,  16'd6,    2'b00}; vn[6] = "1000_7";
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], oq, orr, oovf, odz, lat, bok);
            checks++;
            if ({oq, orr, oovf, odz} !== ve[i] || lat !== 34) begin
                failures++;
                $display("FAIL %s: got q=%h r=%h ovf=%b dz=%b lat=%0d, want q=%h r=%h ovf=%b dz=%b lat=34",
                         vn[i], oq, orr, oovf, odz, lat,
                         ve[i][33:18], ve[i][17:2], ve[i][1], ve[i][0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero;
        logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
        do_op(32'd123, 16'd0, oq, orr, oovf, odz, lat, bok);
        checks++;
        if ({oq, orr, oovf, odz, lat} !== {16'h0, 16'h0, 1'b0, 1'b1, 32'd2}) begin
            failures++;
            $display("FAIL div_zero: got q=%h r=%h ovf=%b dz=%b lat=%0d, want 0 0 0 1 lat=2",
                     oq, orr, oovf, odz, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        logic [15:0] hq, hr; logic hovf, hdz;
        hq = 16'hFF9E; hr = 16'hFFFF; hovf = 1'b0; hdz = 1'b0;
        begin
            logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
            do_op(32'hFFFFE9CB, 16'd58, oq, orr, oovf, odz, lat, bok);
        end
        dividend = 32'd77; divisor = 16'd0;
        repeat (5) @(negedge clk);
        checks++;
        if ({q, r, ovf, dz} !== {hq, hr, hovf, hdz}) begin
            failures++;
            $display("FAIL hold_outputs: got q=%h r=%h ovf=%b dz=%b, want %h %h %b %b",
                     q, r, ovf, dz, hq, hr, hovf, hdz);
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        dones = 0;
        dividend = 32'hFFFFFFCE; divisor = 16'hFFFE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", dones);
        end
        checks++;
        if ({q, r} !== {16'h0019, 16'h0000}) begin
            failures++;
            $display("FAIL ignore_start_result: got q=%h r=%h, want 0019 0000", q, r);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
        do_op(32'd1000, 16'd7, oq, orr, oovf, odz, lat, bok);
        @(negedge clk);
        dividend = 32'd5000; divisor = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, q, r, ovf, dz} !== 35'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all 0",
                     busy, done, q, r, ovf, dz);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", dones);
        end
        do_op(32'd25, 16'd5, oq, orr, oovf, odz, lat, bok);
        checks++;
        if ({oq, orr, lat} !== {16'd5, 16'd0, 32'd34}) begin
            failures++;
            $display("FAIL after_reset_25_5: got q=%h r=%h lat=%0d, want 0005 0000 lat=34",
                     oq, orr, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] oq, orr; logic oovf, odz, bok; int lat;
        do_op(32'd25, 16'd5, oq, orr, oovf, odz, lat, bok);
        // Start held high from the done cycle: ignored there, taken one cycle later
        dividend = 32'd1000; divisor = 16'hFFF9; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_ignored: busy=%b, want 0", busy);
        end
        do_op(32'd1000, 16'hFFF9, oq, orr, oovf, odz, lat, bok);
        checks++;
        if ({oq, orr, oovf, odz, lat} !== {16'hFF72, 16'd6, 1'b0, 1'b0, 32'd34}) begin
            failures++;
            $display("FAIL back_to_back: got q=%h r=%h ovf=%b dz=%b lat=%0d, want ff72 0006 0 0 lat=34",
                     oq, orr, oovf, odz, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 16'd0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_values;
        test_div_zero;
        test_hold;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_div.md
BOOTH_DIV -- requirements
Module: booth_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit dividend and 16-bit divisor, quotient and remainder (the inverse of the 16x16->32 signed multiplier).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  32  signed two's-complement dividend; sampled with start.
REQ-006 divisor  input  16  signed two's-complement divisor; sampled with start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse when q/r/ovf/dz are valid.
REQ-009 q  output  16  signed quotient, truncated toward zero.
REQ-010 r  output  16  signed remainder; sign equals dividend sign, or zero.
REQ-011 ovf  output  1  quotient not representable in 16 signed bits.
REQ-012 dz  output  1  divisor was zero.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; encoding is free.
REQ-014 IDLE with start=1 at edge E0 SHALL latch operands, store magnitudes |dividend| (32b) and |divisor| (16b), and record the quotient and remainder signs.
REQ-015 At E0, divisor!=0 -> CALC with iteration count 0; divisor==0 -> FIX directly with dz pending.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle on the magnitudes (33-bit partial remainder, 32-bit quotient magnitude), for exactly 32 cycles (E1..E32), then enter FIX.
REQ-017 FIX (one cycle) SHALL apply signs and register q, r, ovf, dz, then enter DONE.
REQ-018 Overflow: negative quotient requires magnitude <= 32768; non-negative requires magnitude <= 32767; otherwise ovf=1.
REQ-019 If ovf=1 or dz=1, q and r SHALL be 16'h0000; otherwise ovf=0 and dz=0.
REQ-020 Remainder magnitude always fits 16 bits; r = -mag when dividend is negative, else +mag.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency: done high 34 cycles after the start edge for non-zero divisor, and 2 cycles after it for divisor zero.
REQ-023 start while busy=1 (including in DONE) SHALL be ignored; no queuing.
REQ-024 q, r, ovf, dz SHALL hold their last values until the next FIX; operand changes while busy have no effect.
REQ-025 Back-to-back: start asserted in the cycle after DONE (IDLE) SHALL be accepted.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, q=0, r=0, ovf=0, dz=0, and iteration count 0, regardless of state.
REQ-027 Reset asserted mid-CALC SHALL abort the division with no done pulse; start is accepted again on the first edge after rst deasserts.
REQ-028 rst takes priority over start in the same cycle.

Verification
REQ-029 dividend=-50 (32'hFFFFFFCE), divisor=-2 -> q=16'h0019, r=0, ovf=0, dz=0; done exactly 34 cycles after start; busy high throughout.
REQ-030 Multiplier inverse and boundary cases: dividend=32'h3FFF0001, divisor=16'h7FFF -> q=16'h7FFF, r=0; dividend=32'hC0008000, divisor=16'h7FFF -> q=16'h8000, r=0, ovf=0.
REQ-031 dividend=-5685, divisor=58 -> q=16'hFF9E (-98), r=16'hFFFF (-1).
REQ-032 Overflow cases, each giving ovf=1, q=0, r=0: dividend=32'h40000000, divisor=16'h7FFF; dividend=32'h80000000, divisor=16'hFFFF. dividend=32'h40000000, divisor=16'h8000 -> q=16'h8000, ovf=0.
REQ-033 divisor=0, dividend=123 -> dz=1, q=0, r=0; done 2 cycles after start.
REQ-034 Control cases: start pulsed again at cycle 10 of a running op -> ignored, single done pulse. rst at cycle 15 of CALC -> all outputs 0, no done. Then start with 25/5 -> q=5, r=0 at latency 34.
